// File: rtl/dpi_feeder_pkg.sv
// dpi_feeder_pkg
// Shared types for the DPI stream feeder: FSM state encoding, stream-id
// sizing and the flow-table entry layout. Keys are stored zero-extended to
// MAX_KEY_W so the entry struct does not depend on the top-level KEY_W.
package dpi_feeder_pkg;

  localparam int ID_W        = 6;
  localparam int NUM_STREAMS = 64;
  localparam int MAX_KEY_W   = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LOAD,
    GAP,
    STREAM,
    DRAIN,
    EOP,
    RESULT
  } feeder_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_KEY_W-1:0] key;
  } flow_entry_t;

endpackage

// File: rtl/dpi_flow_table.sv
// dpi_flow_table
// 64-entry flow-key -> stream-id map. One lookup per lookup_en pulse:
// hit returns the matching index, a miss allocates the lowest free entry,
// and a miss on a full table overwrites the round-robin victim.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (clears all entries)
//   lookup_en      perform lookup/allocate on this cycle
//   key            flow key to look up
//   id, is_new     registered result of the last lookup
//   evict_cnt      saturating count of evictions
module dpi_flow_table
  import dpi_feeder_pkg::*;
#(
  parameter int KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_en,
  input  logic [KEY_W-1:0] key,
  output logic [ID_W-1:0]  id,
  output logic             is_new,
  output logic [15:0]      evict_cnt
);

  flow_entry_t          tbl [NUM_STREAMS];
  logic [MAX_KEY_W-1:0] key_ext;
  logic                 hit;
  logic                 has_free;
  logic [ID_W-1:0]      hit_idx;
  logic [ID_W-1:0]      free_idx;
  logic [ID_W-1:0]      victim;

  assign key_ext = MAX_KEY_W'(key);

  // Scanning downward leaves the lowest matching/free index in the result.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (tbl[i].valid && (tbl[i].key == key_ext)) begin
        hit     = 1'b1;
        hit_idx = ID_W'(i);
      end
      if (!tbl[i].valid) begin
        has_free = 1'b1;
        free_idx = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STREAMS; i++) tbl[i] <= '0;
      victim    <= '0;
      evict_cnt <= '0;
      id        <= '0;
      is_new    <= 1'b0;
    end else if (lookup_en) begin
      if (hit) begin
        id     <= hit_idx;
        is_new <= 1'b0;
      end else if (has_free) begin
        id            <= free_idx;
        is_new        <= 1'b1;
        tbl[free_idx] <= '{valid: 1'b1, key: key_ext};
      end else begin
        id          <= victim;
        is_new      <= 1'b1;
        tbl[victim] <= '{valid: 1'b1, key: key_ext};
        victim      <= victim + ID_W'(1);
        if (evict_cnt != 16'hFFFF) evict_cnt <= evict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/dpi_stream_feeder.sv
// dpi_stream_feeder
// Front end of the regex matcher bank. Maps each packet's flow key to a
// stream id, then sequences load_state -> chars -> eop and emits one result
// record per packet.
// Optional feature macro: DPI_STALL_TIMEOUT_EN (stall timeout / abort).
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready/in_data/in_sop/in_eop/in_key/in_cat_en   packet input
//   load_state/stream_id/new_stream_id/char_in/char_in_vld/eop/enable
//                               matcher bank drive
//   fired_in                    matcher fired vector
//   res_valid/res_stream_id/res_fired/res_new/res_abort   result record
//   evict_cnt, proto_err        status
//
// state  | meaning
// IDLE   | wait for sop; non-sop beats are dropped (proto_err)
// LOOKUP | flow-table lookup/allocate with the latched key
// LOAD   | load_state pulse, matchers restore/clear state
// GAP    | matcher restore latency
// STREAM | accept beats, forward chars with one cycle latency
// DRAIN  | matcher accept pipeline drain
// EOP    | eop pulse, sample fired_in & enable
// RESULT | res_valid pulse
module dpi_stream_feeder
  import dpi_feeder_pkg::*;
#(
  parameter int NUM_CAT   = 8,
  parameter int KEY_W     = 32,
  parameter int LOAD_GAP  = 2,
  parameter int EOP_GAP   = 2,
  parameter int STALL_MAX = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [KEY_W-1:0]   in_key,
  input  logic [NUM_CAT-1:0] in_cat_en,
  output logic               load_state,
  output logic [ID_W-1:0]    stream_id,
  output logic               new_stream_id,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic               eop,
  output logic [NUM_CAT-1:0] enable,
  input  logic [NUM_CAT-1:0] fired_in,
  output logic               res_valid,
  output logic [ID_W-1:0]    res_stream_id,
  output logic [NUM_CAT-1:0] res_fired,
  output logic               res_new,
  output logic               res_abort,
  output logic [15:0]        evict_cnt,
  output logic               proto_err
);

  localparam int CNT_W = 8;

  feeder_state_e      state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [KEY_W-1:0]   key_r;
  logic [NUM_CAT-1:0] en_r;
  logic [NUM_CAT-1:0] res_fired_r;
  logic [7:0]         char_r;
  logic               char_vld_r;
  logic               proto_err_r;
  logic               first_beat;
  logic               accept;
  logic               ft_new;
  logic               timeout;
  logic               abort_r;

  dpi_flow_table #(.KEY_W(KEY_W)) u_flow_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .lookup_en (state == LOOKUP),
    .key       (key_r),
    .id        (stream_id),
    .is_new    (ft_new),
    .evict_cnt (evict_cnt)
  );

  assign accept = in_valid & in_ready;

`ifdef DPI_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(STALL_MAX + 1);
  logic [STALL_W-1:0] stall_cnt;

  // Down-counter reloaded on every accepted beat; terminal count aborts.
  always_ff @(posedge clk) begin
    if (!rst_n || state != STREAM || accept) stall_cnt <= STALL_W'(STALL_MAX - 1);
    else if (stall_cnt != '0)                stall_cnt <= stall_cnt - STALL_W'(1);
  end

  assign timeout = (state == STREAM) && !in_valid && (stall_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || state == LOOKUP) abort_r <= 1'b0;
    else if (timeout)              abort_r <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign abort_r = 1'b0;
`endif

  // The sop beat is only latched here; it is consumed later in STREAM.
  // A single-cycle GAP budget is covered by the first STREAM cycle itself,
  // since chars leave one cycle after acceptance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = in_valid & ~in_sop;
        if (in_valid && in_sop) state_nxt = LOOKUP;
      end
      LOOKUP: state_nxt = LOAD;
      LOAD: begin
        if (LOAD_GAP > 1) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_W'(LOAD_GAP - 2);
        end else begin
          state_nxt = STREAM;
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = STREAM;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      STREAM: begin
        in_ready = 1'b1;
        if (in_valid && in_eop) begin
          state_nxt = DRAIN;
          cnt_nxt   = CNT_W'(EOP_GAP);
        end else if (timeout) begin
          state_nxt = EOP;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = EOP;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      EOP:     state_nxt = RESULT;
      RESULT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // On an aborted packet the matchers must see enable=0 with eop.
  always_comb begin
    enable = '0;
    if (state inside {LOAD, GAP, STREAM, DRAIN, EOP}) enable = en_r;
    if (state == EOP && abort_r) enable = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_r       <= '0;
      en_r        <= '0;
      char_r      <= '0;
      char_vld_r  <= 1'b0;
      res_fired_r <= '0;
      proto_err_r <= 1'b0;
      first_beat  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      char_vld_r <= (state == STREAM) && accept;
      if (state == IDLE && in_valid && in_sop) begin
        key_r <= in_key;
        en_r  <= in_cat_en;
      end
      if (state == STREAM && accept) char_r <= in_data;
      if (state == LOOKUP)                 first_beat <= 1'b1;
      else if (state == STREAM && accept)  first_beat <= 1'b0;
      // The held sop beat legitimately arrives first; any later sop is data.
      if ((state == IDLE && in_valid && !in_sop) ||
          (state == STREAM && accept && in_sop && !first_beat))
        proto_err_r <= 1'b1;
      if (state == EOP) res_fired_r <= fired_in & enable;
    end
  end

  assign load_state    = (state == LOAD);
  assign new_stream_id = (state == LOAD) & ft_new;
  assign char_in       = char_r;
  assign char_in_vld   = char_vld_r;
  assign eop           = (state == EOP);
  assign res_valid     = (state == RESULT);
  assign res_stream_id = stream_id;
  assign res_fired     = res_fired_r;
  assign res_new       = ft_new;
  assign res_abort     = abort_r;
  assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_dpi_stream_feeder.sv
`timescale 1ns/1ps
module tb_dpi_stream_feeder;

  localparam int NUM_CAT = 8;
  localparam int KEY_W   = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         in_data = '0;
  logic               in_sop = 1'b0;
  logic               in_eop = 1'b0;
  logic [KEY_W-1:0]   in_key = '0;
  logic [NUM_CAT-1:0] in_cat_en = '0;
  logic               load_state;
  logic [5:0]         stream_id;
  logic               new_stream_id;
  logic [7:0]         char_in;
  logic               char_in_vld;
  logic               eop;
  logic [NUM_CAT-1:0] enable;
  logic [NUM_CAT-1:0] fired_in = '0;
  logic               res_valid;
  logic [5:0]         res_stream_id;
  logic [NUM_CAT-1:0] res_fired;
  logic               res_new;
  logic               res_abort;
  logic [15:0]        evict_cnt;
  logic               proto_err;

  always #5 clk = ~clk;

  dpi_stream_feeder #(.NUM_CAT(NUM_CAT), .KEY_W(KEY_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_key        (in_key),
    .in_cat_en     (in_cat_en),
    .load_state    (load_state),
    .stream_id     (stream_id),
    .new_stream_id (new_stream_id),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .enable        (enable),
    .fired_in      (fired_in),
    .res_valid     (res_valid),
    .res_stream_id (res_stream_id),
    .res_fired     (res_fired),
    .res_new       (res_new),
    .res_abort     (res_abort),
    .evict_cnt     (evict_cnt),
    .proto_err     (proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Event monitor: sampled on the falling edge, cleared when mon_gen moves.
  int          mon_gen = 0;
  int          seen_gen = 0;
  int          cyc = 0;
  int          n_load, n_char, n_eop, n_res;
  int          load_cyc, first_cyc, last_cyc, eop_cyc;
  logic [5:0]  load_id, r_id;
  logic        load_new, r_new, r_abort;
  logic [7:0]  load_en, eop_en, r_fired;
  logic [31:0] char_log;

  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (seen_gen != mon_gen) begin
        seen_gen = mon_gen;
        n_load = 0; n_char = 0; n_eop = 0; n_res = 0;
        load_cyc = 0; first_cyc = 0; last_cyc = 0; eop_cyc = 0;
        load_id = '0; r_id = '0; load_new = 1'b0; r_new = 1'b0; r_abort = 1'b0;
        load_en = '0; eop_en = '0; r_fired = '0; char_log = '0;
      end
      if (load_state) begin
        n_load++; load_cyc = cyc; load_id = stream_id;
        load_new = new_stream_id; load_en = enable;
      end
      if (char_in_vld) begin
        n_char++;
        if (n_char == 1) first_cyc = cyc;
        last_cyc = cyc;
        char_log = {char_log[23:0], char_in};
      end
      if (eop) begin
        n_eop++; eop_cyc = cyc; eop_en = enable;
      end
      if (res_valid) begin
        n_res++; r_id = res_stream_id; r_new = res_new;
        r_fired = res_fired; r_abort = res_abort;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic sop, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = last;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!done) check_val("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_res();
    int t = 0;
    while (n_res == 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (n_res == 0) check_val("res_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pkt(input logic [31:0] key, input logic [7:0] mask,
                          input int nbytes, input int gap);
    mon_gen++;
    in_key = key; in_cat_en = mask;
    for (int i = 0; i < nbytes; i++) begin
      drive_beat(8'h61 + 8'(i), i == 0, i == nbytes - 1);
      if (gap > 0 && i != nbytes - 1) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    wait_res();
  endtask

  initial begin
    do_reset();

    // Reset state
    @(negedge clk);
    check_val("rst_load_state", load_state, 0);
    check_val("rst_eop", eop, 0);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_char_vld", char_in_vld, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_enable", enable, 0);
    check_val("rst_proto_err", proto_err, 0);
    check_val("rst_evict_cnt", evict_cnt, 0);
    @(posedge clk);
    #1;

    // First packet: new stream 0, 3 chars, timing of load->char->eop
    fired_in = 8'h00;
    send_pkt(32'h0A000001, 8'hFF, 3, 0);
    check_val("p1_n_load", n_load, 1);
    check_val("p1_stream_id", load_id, 0);
    check_val("p1_new", load_new, 1);
    check_val("p1_load_en", load_en, 8'hFF);
    check_val("p1_n_char", n_char, 3);
    check_val("p1_first_char_lat", first_cyc - load_cyc, 3);
    check_val("p1_b2b", last_cyc - first_cyc, 2);
    check_val("p1_chars", char_log, 32'h00616263);
    check_val("p1_n_eop", n_eop, 1);
    check_val("p1_eop_lat", eop_cyc - last_cyc, 3);
    check_val("p1_eop_en", eop_en, 8'hFF);
    check_val("p1_res_new", r_new, 1);
    check_val("p1_res_id", r_id, 0);
    check_val("p1_res_fired", r_fired, 8'h00);
    check_val("p1_proto_err", proto_err, 0);

    // Same key again: hit, fired masked by enable
    fired_in = 8'h35;
    send_pkt(32'h0A000001, 8'h0F, 2, 0);
    fired_in = 8'h00;
    check_val("p2_stream_id", load_id, 0);
    check_val("p2_new", load_new, 0);
    check_val("p2_load_en", load_en, 8'h0F);
    check_val("p2_res_fired", r_fired, 8'h05);
    check_val("p2_res_new", r_new, 0);

    // Fill entries 1..63, then evict round robin
    for (int i = 1; i < 64; i++) begin
      send_pkt(32'h10000000 + i, 8'h01, 1, 0);
      check_val("fill_id", load_id, i);
    end
    check_val("full_evict_cnt", evict_cnt, 0);
    send_pkt(32'h20000000, 8'h01, 1, 0);
    check_val("ev1_id", load_id, 0);
    check_val("ev1_new", load_new, 1);
    check_val("ev1_cnt", evict_cnt, 1);
    send_pkt(32'h20000001, 8'h01, 1, 0);
    check_val("ev2_id", load_id, 1);
    check_val("ev2_cnt", evict_cnt, 2);
    send_pkt(32'h10000002, 8'h01, 1, 0);
    check_val("hit2_id", load_id, 2);
    check_val("hit2_new", load_new, 0);
    check_val("hit2_cnt", evict_cnt, 2);
    send_pkt(32'h0A000001, 8'h01, 1, 0);
    check_val("ev3_id", load_id, 2);
    check_val("ev3_new", load_new, 1);
    check_val("ev3_cnt", evict_cnt, 3);

    // Non-sop beat in IDLE: dropped, sticky proto_err
    mon_gen++;
    drive_beat(8'h55, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check_val("drop_n_load", n_load, 0);
    check_val("drop_n_char", n_char, 0);
    check_val("drop_n_eop", n_eop, 0);
    check_val("drop_proto_err", proto_err, 1);

    // One-beat packet, then a packet with input gaps
    send_pkt(32'h30000000, 8'hAA, 1, 0);
    check_val("one_id", load_id, 3);
    check_val("one_n_char", n_char, 1);
    check_val("one_n_eop", n_eop, 1);
    check_val("one_char", char_log, 32'h00000061);
    check_val("one_eop_lat", eop_cyc - last_cyc, 3);
    check_val("one_evict_cnt", evict_cnt, 4);
    check_val("sticky_proto_err", proto_err, 1);
    send_pkt(32'h30000000, 8'hAA, 3, 2);
    check_val("gap_id", load_id, 3);
    check_val("gap_new", load_new, 0);
    check_val("gap_n_char", n_char, 3);
    check_val("gap_chars", char_log, 32'h00616263);
    check_val("gap_spacing", last_cyc - first_cyc, 6);
    check_val("gap_n_eop", n_eop, 1);
    check_val("gap_eop_lat", eop_cyc - last_cyc, 3);

    // Reset in the middle of STREAM
    mon_gen++;
    in_key = 32'h40000000; in_cat_en = 8'hFF;
    drive_beat(8'h71, 1'b1, 1'b0);
    drive_beat(8'h72, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_val("mrst_n_eop", n_eop, 0);
    check_val("mrst_n_res", n_res, 0);
    check_val("mrst_proto_err", proto_err, 0);
    check_val("mrst_evict_cnt", evict_cnt, 0);
    send_pkt(32'h10000005, 8'h01, 1, 0);
    check_val("clr_id", load_id, 0);
    check_val("clr_new", load_new, 1);

    // sop on a later STREAM beat is data and flags an error
    mon_gen++;
    in_key = 32'h50000000; in_cat_en = 8'h01;
    drive_beat(8'h81, 1'b1, 1'b0);
    drive_beat(8'h82, 1'b1, 1'b0);
    drive_beat(8'h83, 1'b0, 1'b1);
    wait_res();
    check_val("sop2_id", load_id, 1);
    check_val("sop2_n_char", n_char, 3);
    check_val("sop2_chars", char_log, 32'h00818283);
    check_val("sop2_proto_err", proto_err, 1);
    check_val("sop2_res_abort", r_abort, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dpi_stream_feeder.md
Name: dpi_stream_feeder

Overview:
Front end of the packet-inspection engine. It drives the per-category regex matcher bank. It accepts packet bytes tagged with a flow key, maps each key to a 6-bit stream id through a 64-entry flow table, and sequences the matcher protocol: load_state, then characters, then eop. It then samples the bank's fired vector and emits one result record per packet.

Parameters:
NUM_CAT, 8, number of category matchers driven in parallel
KEY_W, 32, flow key width (e.g. source IP)
LOAD_GAP, 2, idle cycles between load_state and first char (matcher state restore latency)
EOP_GAP, 2, idle cycles between last char and eop (matcher accept pipeline drain)
STALL_MAX, 255, stall timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  8  packet byte
in_sop  in  1  first beat of packet; in_key/in_cat_en valid on this beat
in_eop  in  1  last beat of packet
in_key  in  KEY_W  flow key
in_cat_en  in  NUM_CAT  per-category enable mask for this packet
load_state  out  1  one-cycle pulse: restore or clear matcher state
stream_id  out  6  stream id, stable from load_state through eop
new_stream_id  out  1  qualifies load_state: the stream was newly allocated
char_in  out  8  character to matchers
char_in_vld  out  1  char_in valid
eop  out  1  one-cycle end-of-packet pulse to matchers
enable  out  NUM_CAT  per-matcher enable, stable from load_state through eop
fired_in  in  NUM_CAT  fired outputs of the matchers
res_valid  out  1  one-cycle result pulse
res_stream_id  out  6  stream id of the result
res_fired  out  NUM_CAT  fired_in & enable, sampled in the eop cycle
res_new  out  1  packet opened a new stream
res_abort  out  1  packet aborted (optional feature only; otherwise 0)
evict_cnt  out  16  count of flow-table evictions, saturating
proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset: all outputs 0. FSM enters IDLE. All flow-table entries invalid. Victim pointer 0.
- FSM states: IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP, RESULT.
- IDLE
  - in_valid & in_sop: latch in_key and in_cat_en, go to LOOKUP. The sop beat is not consumed.
  - in_valid & ~in_sop: beat is dropped (in_ready=1) and proto_err is set.
- LOOKUP (1 cycle)
  - Parallel compare against all valid entries.
  - Hit: stream_id = index, new = 0.
  - Miss with a free entry: allocate the lowest free index, new = 1.
  - Miss with table full: overwrite the entry at the victim pointer, new = 1, victim pointer +1 (wraps 63->0), evict_cnt +1.
- LOAD (1 cycle): load_state = 1. new_stream_id = new. enable = latched mask.
- GAP: LOAD_GAP cycles with no output activity.
- STREAM
  - in_ready = 1.
  - Each accepted beat drives char_in/char_in_vld registered, 1-cycle latency, back to back.
  - in_sop on a STREAM beat is treated as data and sets proto_err.
  - Accepted beat with in_eop goes to DRAIN.
  - sop and eop on the same beat is a legal one-char packet.
- DRAIN: EOP_GAP cycles, then EOP.
- EOP (1 cycle): eop = 1. Register res_fired = fired_in & enable.
- RESULT (1 cycle): res_valid = 1 with res_stream_id/res_new, then return to IDLE.
- in_ready = 0 in all states other than STREAM and the IDLE drop case.
- No result backpressure.
- Reset mid-packet: immediate return to IDLE. The flow table is cleared. No eop is generated.

Optional Feature:
DPI_STALL_TIMEOUT_EN
- With the macro: in STREAM, a counter counts consecutive cycles without an accepted beat. When it reaches STALL_MAX, the block goes to EOP with enable forced to 0 for that eop cycle. The matchers then discard the speculative match and do not save state. res_valid is still pulsed, with res_abort = 1 and res_fired = 0. The remaining beats of that packet arrive in IDLE without sop and are dropped, setting proto_err.
- Without the macro: STREAM waits indefinitely and res_abort is tied to 0.

Decomposition:
- Package dpi_feeder_pkg: FSM state enum, ID_W = 6, NUM_STREAMS = 64, flow-entry struct {valid, key}.
- Sub-module dpi_flow_table: lookup, lowest-free allocate, round-robin evict, evict_cnt. Its outputs are registered into LOOKUP.

Test Plan:
- Key 0x0A000001, 3-byte packet, mask 0xFF → load_state with new_stream_id=1 and stream_id=0; char_in_vld pulses 3 cycles starting LOAD_GAP+1 after load_state; eop EOP_GAP+1 after last char; res_new=1.
- Same key again with fired_in=0x05 during eop, mask 0x0F → stream_id=0, new_stream_id=0, res_fired=0x05.
- 65 distinct keys → 65th gets stream_id 0 with new_stream_id=1, evict_cnt=1; a 66th distinct key gets stream_id 1.
- Non-sop beat in IDLE → consumed, no matcher activity, proto_err=1 sticky until reset.
- One-beat packet (sop & eop) with in_valid gaps elsewhere → exactly one char_in_vld and one eop; rst_n low mid-STREAM → no eop, table empty afterwards.
- With DPI_STALL_TIMEOUT_EN, STALL_MAX=16, stall after 2 bytes → eop with enable=0 at cycle 16 of stall, res_abort=1, res_fired=0.
